// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: CPU-side register map and OAM DMA state encoding shared by NES bus blocks.
`default_nettype none

package nes_bus_pkg;

  localparam logic [15:0] PPU_CTRL_ADDR   = 16'h2000;
  localparam logic [15:0] PPU_MASK_ADDR   = 16'h2001;
  localparam logic [15:0] PPU_STATUS_ADDR = 16'h2002;
  localparam logic [15:0] OAM_ADDR_ADDR   = 16'h2003;
  localparam logic [15:0] OAM_DATA_ADDR   = 16'h2004;
  localparam logic [15:0] PPU_SCROLL_ADDR = 16'h2005;
  localparam logic [15:0] PPU_ADDR_ADDR   = 16'h2006;
  localparam logic [15:0] PPU_DATA_ADDR   = 16'h2007;
  localparam logic [15:0] DMA_REG_ADDR    = 16'h4014;
  localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
  localparam logic [15:0] JOY1_ADDR       = 16'h4016;
  localparam logic [15:0] JOY2_ADDR       = 16'h4017;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t HALT  = 3'd1;
  localparam state_t ALIGN = 3'd2;
  localparam state_t READ  = 3'd3;
  localparam state_t WRITE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if: CPU snoop inputs plus the system-bus master signals of the OAM DMA engine.
`default_nettype none

interface oam_dma_ctrl_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  bus_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;

  modport master (
    input  cpu_addr, cpu_dout, cpu_we, bus_din,
    output rdy, dma_active, bus_addr, bus_dout, bus_we
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_we, bus_din,
    input  rdy, dma_active, bus_addr, bus_dout, bus_we
  );

endinterface

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA; a CPU write to the DMA register halts the CPU and copies one
// source page to the PPU OAM data port, one read/write pair per two cycles, reads on even cycles.
`default_nettype none

module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
  parameter int          XFER_LEN_LOG2 = 8
) (
  input  wire logic       clk_ph1,
  input  wire logic       rst,
  oam_dma_ctrl_if.master  bus
);

  import nes_bus_pkg::*;

  localparam logic [XFER_LEN_LOG2-1:0] IDX_ONE = {{(XFER_LEN_LOG2-1){1'b0}}, 1'b1};

  state_t                   state;
  state_t                   state_nxt;
  logic                     parity;
  logic [7:0]               page;
  logic [XFER_LEN_LOG2-1:0] idx;
  logic [7:0]               data;
  logic                     trigger;

  assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

  // parity=1 in HALT means the following cycle is even, so READ can follow directly.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = trigger ? HALT : IDLE;
      HALT:    state_nxt = parity ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (idx == '1) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= '0;
      idx    <= '0;
      data   <= '0;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      case (state)
        IDLE:    if (trigger) page <= bus.cpu_dout;
        READ:    data <= bus.bus_din;
        WRITE:   idx <= idx + IDX_ONE;
        default: ;
      endcase
    end
  end

  // Bus outputs decode only registered state, never the CPU inputs.
  always_comb begin
    bus.rdy        = 1'b1;
    bus.dma_active = 1'b0;
    bus.bus_addr   = '0;
    bus.bus_dout   = '0;
    bus.bus_we     = 1'b0;
    case (state)
      HALT, ALIGN: begin
        bus.rdy        = 1'b0;
        bus.dma_active = 1'b1;
      end
      READ: begin
        bus.rdy        = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = 16'({page, idx});
      end
      WRITE: begin
        bus.rdy        = 1'b0;
        bus.dma_active = 1'b1;
        bus.bus_addr   = OAM_DATA_ADDR;
        bus.bus_dout   = data;
        bus.bus_we     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed scenarios with a write scoreboard fed from the memory model.
`default_nettype none

module tb_oam_dma_ctrl;

  logic clk_ph1 = 1'b0;
  logic rst;
  always #5 clk_ph1 = ~clk_ph1;

  oam_dma_ctrl_if bus_if ();

  oam_dma_ctrl dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (bus_if.master)
  );

  logic [7:0] mem [0:65535];
  assign bus_if.bus_din = mem[bus_if.bus_addr];

  // Independent model of the even/odd cycle phase.
  logic tb_par;
  always @(posedge clk_ph1) tb_par <= rst ? 1'b0 : ~tb_par;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger in the current cycle and follow the transfer until rdy returns.
  task automatic do_xfer(input logic [7:0] pg);
    int halted = 0, reads = 0, writes = 0, bad_rd = 0, stalls = 0;
    logic [31:0] exp_len;
    bus_if.cpu_addr = 16'h4014;
    bus_if.cpu_dout = pg;
    bus_if.cpu_we   = 1'b1;
    exp_len = tb_par ? 32'd514 : 32'd513;
    for (int i = 0; i < 256; i++) exp_q.push_back(mem[{pg, i[7:0]}]);
    @(posedge clk_ph1); #1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    for (int b = 0; b < 700; b++) begin
      @(negedge clk_ph1);
      if (bus_if.rdy) break;
      halted++;
      if (bus_if.bus_we) begin
        writes++;
        chk("wr_addr", 32'(bus_if.bus_addr), 32'h2004);
        if (exp_q.size() > 0) chk("wr_data", 32'(bus_if.bus_dout), 32'(exp_q.pop_front()));
        else chk("wr_extra", 32'(writes), 32'd256);
      end else if (bus_if.bus_addr != 16'h0000) begin
        if (tb_par !== 1'b0 || bus_if.bus_addr !== {pg, reads[7:0]}) bad_rd++;
        reads++;
      end else begin
        stalls++;
      end
    end
    chk("halt_len",   32'(halted), exp_len);
    chk("reads",      32'(reads), 32'd256);
    chk("writes",     32'(writes), 32'd256);
    chk("bad_reads",  32'(bad_rd), 32'd0);
    chk("stalls",     32'(stalls), exp_len - 32'd512);
    chk("end_active", 32'(bus_if.dma_active), 32'd0);
    chk("queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] na_addr [3];
    logic        na_we   [3];
    int w;
    int stray;
    na_addr = '{16'h4015, 16'h4013, 16'h4014};
    na_we   = '{1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[{8'h07, i[7:0]}] = i[7:0] ^ 8'hA5;

    rst = 1'b1;
    bus_if.cpu_addr = '0;
    bus_if.cpu_dout = '0;
    bus_if.cpu_we   = 1'b0;
    repeat (2) @(posedge clk_ph1);
    @(negedge clk_ph1);
    chk("rst_rdy",    32'(bus_if.rdy), 32'd1);
    chk("rst_active", 32'(bus_if.dma_active), 32'd0);
    chk("rst_addr",   32'(bus_if.bus_addr), 32'd0);
    chk("rst_dout",   32'(bus_if.bus_dout), 32'd0);
    chk("rst_we",     32'(bus_if.bus_we), 32'd0);
    @(posedge clk_ph1); #1;
    rst = 1'b0;

    // HALT on an odd cycle: trigger during an even one.
    while (tb_par !== 1'b0) begin @(posedge clk_ph1); #1; end
    do_xfer(8'h02);

    // HALT on an even cycle: one ALIGN inserted.
    repeat (3) @(posedge clk_ph1); #1;
    while (tb_par !== 1'b1) begin @(posedge clk_ph1); #1; end
    do_xfer(8'h02);

    repeat (2) @(posedge clk_ph1); #1;
    do_xfer(8'h07);

    // Non-trigger accesses around the DMA register.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_ph1); #1;
      bus_if.cpu_addr = na_addr[k];
      bus_if.cpu_dout = 8'h02;
      bus_if.cpu_we   = na_we[k];
      @(posedge clk_ph1); #1;
      bus_if.cpu_we   = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_ph1);
        chk("nt_rdy",    32'(bus_if.rdy), 32'd1);
        chk("nt_active", 32'(bus_if.dma_active), 32'd0);
      end
    end

    // Reset during the WRITE of idx $40.
    @(posedge clk_ph1); #1;
    bus_if.cpu_addr = 16'h4014;
    bus_if.cpu_dout = 8'h02;
    bus_if.cpu_we   = 1'b1;
    @(posedge clk_ph1); #1;
    bus_if.cpu_we   = 1'b0;
    w = 0;
    for (int b = 0; b < 300; b++) begin
      @(negedge clk_ph1);
      if (bus_if.bus_we) begin
        if (w == 8'h40) begin
          chk("rst_mid_data", 32'(bus_if.bus_dout), 32'(mem[16'h0240]));
          rst = 1'b1;
          break;
        end
        w++;
      end
    end
    chk("rst_mid_reached", 32'(rst), 32'd1);
    @(posedge clk_ph1); #1;
    rst = 1'b0;
    @(negedge clk_ph1);
    chk("post_rst_rdy",    32'(bus_if.rdy), 32'd1);
    chk("post_rst_we",     32'(bus_if.bus_we), 32'd0);
    chk("post_rst_active", 32'(bus_if.dma_active), 32'd0);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_ph1);
      if (bus_if.bus_we !== 1'b0 || bus_if.rdy !== 1'b1) stray++;
    end
    chk("post_rst_quiet", 32'(stray), 32'd0);
    do_xfer(8'h02);

    // Back-to-back: second trigger in the first cycle after completion.
    @(posedge clk_ph1); #1;
    do_xfer(8'h02);
    do_xfer(8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
